// File: rtl/mul_bf16_arb.sv
// mul_bf16_arb: shares one external pipelined bf16 multiplier among NREQ
// requesters. Operands are granted round-robin, sent to the multiplier with a
// strobe, and the result is routed back to its requester through a tag pipe
// that tracks the multiplier latency. A drain handshake empties the pipe.
// Optional feature: define MUL_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (lowest valid index wins).
module mul_bf16_arb #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mul_in,
  output logic                 mul_in_stb,
  input  logic [15:0]          mul_z,
  input  logic                 mul_z_stb,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_z,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic                 busy,
  output logic                 tag_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Worst case holds MUL_LAT+2 operations: one per cycle from transfer to rsp_valid.
  localparam int CW = $clog2(MUL_LAT + 3);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   start_idx;
  logic [IW-1:0]   grant_idx;
  logic [IW:0]     cand;
  logic            transfer;
  logic            issue_ok;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;
  logic [IW-1:0]   in_idx;
  logic            tag_v   [MUL_LAT];
  logic [IW-1:0]   tag_idx [MUL_LAT];
  logic [CW-1:0]   count;

  // Grants are only offered while running, not draining, and not in reset.
  assign issue_ok = (state == RUN) && !drain_req && !rst;
  assign busy     = (count != '0);

`ifdef MUL_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [IW-1:0] ptr;

  assign start_idx = ptr;

  // Round-robin pointer moves just past the requester that last transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  // Search valid requesters starting at start_idx and grant the first one found.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    transfer  = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, start_idx} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (issue_ok && !transfer && req_valid[cand[IW-1:0]]) begin
        transfer                  = 1'b1;
        grant_idx                 = cand[IW-1:0];
        req_ready[cand[IW-1:0]]   = 1'b1;
      end
    end
  end

  // Pick the granted requester's operand pair out of the packed buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain sequencing: stop issuing, wait for the pipe to empty, then release.
  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      RUN: begin
        if (drain_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (count == '0) state_nxt = DONE;
      end
      DONE: begin
        drain_done = 1'b1;
        if (!drain_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Register granted operands toward the multiplier with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_in     <= '0;
      mul_in_stb <= 1'b0;
      in_idx     <= '0;
    end else begin
      mul_in_stb <= transfer;
      if (transfer) begin
        mul_in <= {sel_a, sel_b};
        in_idx <= grant_idx;
      end
    end
  end

  // Tag pipe follows each strobe so its tail lines up with the multiplier result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_v[i]   <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      tag_v[0]   <= mul_in_stb;
      tag_idx[0] <= in_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // Route a tagged result to its requester; an untagged result latches tag_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_z     <= '0;
      tag_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (mul_z_stb) begin
        if (tag_v[MUL_LAT-1]) begin
          rsp_valid <= NREQ'(1) << tag_idx[MUL_LAT-1];
          rsp_z     <= mul_z;
        end else begin
          tag_err <= 1'b1;
        end
      end
    end
  end

  // In-flight count spans from transfer until the response strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (transfer && !(|rsp_valid)) begin
      count <= count + 1'b1;
    end else if (!transfer && (|rsp_valid)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_bf16_arb.sv
// tb_mul_bf16_arb: randomized self-checking bench for mul_bf16_arb.
// Drives inputs on the falling edge, checks outputs 1 ns later, and compares
// against a transaction-level model (list of granted operations with their
// issue cycle) rather than a copy of the design's pipeline.
module tb_mul_bf16_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [16*NREQ-1:0]  req_a;
  logic [16*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         mul_in;
  logic                mul_in_stb;
  logic [15:0]         mul_z;
  logic                mul_z_stb;
  logic [NREQ-1:0]     rsp_valid;
  logic [15:0]         rsp_z;
  logic                drain_req;
  logic                drain_done;
  logic                busy;
  logic                tag_err;
  logic                force_stb;

  logic                mp_v [LAT];
  logic [15:0]         mp_z [LAT];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit do_check = 0;

  typedef struct {
    int          cyc;
    int          idx;
    logic [15:0] z;
  } rec_t;

  rec_t        recs[$];
  int          mode      = 0;
  int          ptr       = 0;
  logic        tag_err_m = 1'b0;
  logic [31:0] last_in   = '0;
  int          drain_hold = 0;

  mul_bf16_arb #(.NREQ(NREQ), .MUL_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_in     (mul_in),
    .mul_in_stb (mul_in_stb),
    .mul_z      (mul_z),
    .mul_z_stb  (mul_z_stb),
    .rsp_valid  (rsp_valid),
    .rsp_z      (rsp_z),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .busy       (busy),
    .tag_err    (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating bf16 multiply for normal operands: sign xor, exponent add,
  // 8x8 significand product renormalised to 7 fraction bits.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          e;
    logic [15:0] p;
    logic [6:0]  m;
    s = a[15] ^ b[15];
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    if (p[15]) begin
      m = p[14:8];
      e = e + 1;
    end else begin
      m = p[13:7];
    end
    return {s, 8'(e), m};
  endfunction

  // External multiplier stand-in: fixed latency LAT, shares the reset.
  assign mul_z_stb = mp_v[LAT-1] | force_stb;
  assign mul_z     = mp_z[LAT-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        mp_v[i] <= 1'b0;
        mp_z[i] <= '0;
      end
    end else begin
      mp_v[0] <= mul_in_stb;
      mp_z[0] <= bf16_mul(mul_in[31:16], mul_in[15:0]);
      for (int i = 1; i < LAT; i++) begin
        mp_v[i] <= mp_v[i-1];
        mp_z[i] <= mp_z[i-1];
      end
    end
  end

  // Arbitration rule: first valid requester at or after the pointer.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int start;
    start = p;
`ifdef MUL_ARB_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (start + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] r;
    r[15]   = 1'($urandom_range(0, 1));
    r[14:7] = 8'($urandom_range(110, 140));
    r[6:0]  = 7'($urandom);
    return r;
  endfunction

  task automatic randOps();
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = rand_bf16();
      req_b[16*i +: 16] = rand_bf16();
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance
  // the model across the coming rising edge, then wait for the next fall.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic drn,
                               input logic frc, input logic rs);
    int              g;
    int              cnt;
    bit              tag_hit;
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] rv_e;
    logic [15:0]     rz_e;
    logic            stb_e;

    req_valid = v;
    drain_req = drn;
    force_stb = frc;
    rst       = rs;
    #1;

    g  = pick(v, ptr);
    er = '0;
    if (!rs && mode == 0 && !drn && g >= 0) er[g] = 1'b1;

    stb_e   = 1'b0;
    rv_e    = '0;
    rz_e    = '0;
    cnt     = 0;
    tag_hit = 0;
    foreach (recs[i]) begin
      if (recs[i].cyc + 1 == cyc) stb_e = 1'b1;
      if (recs[i].cyc + LAT + 2 == cyc) begin
        rv_e[recs[i].idx] = 1'b1;
        rz_e = recs[i].z;
      end
      if (recs[i].cyc + LAT + 1 == cyc) tag_hit = 1;
      if (recs[i].cyc + 1 <= cyc && cyc <= recs[i].cyc + LAT + 2) cnt++;
    end

    if (do_check) begin
      checkOutput("req_ready",  32'(req_ready),  32'(er));
      checkOutput("mul_in_stb", 32'(mul_in_stb), 32'(stb_e));
      checkOutput("mul_in",     mul_in,          last_in);
      checkOutput("rsp_valid",  32'(rsp_valid),  32'(rv_e));
      if (rv_e != '0) checkOutput("rsp_z", 32'(rsp_z), 32'(rz_e));
      checkOutput("busy",       32'(busy),       32'(cnt != 0));
      checkOutput("drain_done", 32'(drain_done), 32'(mode == 2));
      checkOutput("tag_err",    32'(tag_err),    32'(tag_err_m));
    end

    if (rs) begin
      recs.delete();
      mode      = 0;
      ptr       = 0;
      tag_err_m = 1'b0;
      last_in   = '0;
    end else begin
      if (frc && !tag_hit) tag_err_m = 1'b1;
      if (mode == 0 && drn)       mode = 1;
      else if (mode == 1 && cnt == 0) mode = 2;
      else if (mode == 2 && !drn) mode = 0;
      if (er != '0) begin
        recs.push_back('{cyc, g, bf16_mul(req_a[16*g +: 16], req_b[16*g +: 16])});
        last_in = {req_a[16*g +: 16], req_b[16*g +: 16]};
        ptr = (g + 1) % NREQ;
      end
      while (recs.size() > 0 && recs[0].cyc + LAT + 2 < cyc) void'(recs.pop_front());
    end

    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus('0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    drain_req = 1'b0;
    force_stb = 1'b0;
    @(negedge clk);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    do_check = 1;
    idle(1);

    // Single request: 1.0 * 2.0 from requester 0.
    req_a[15:0] = 16'h3F80;
    req_b[15:0] = 16'h4000;
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    idle(7);

    // All requesters valid continuously: back-to-back round-robin grants.
    repeat (8) begin
      randOps();
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    end
    idle(7);

    // Requester 2 computes 1.5 * 2.0 alongside requester 0.
    randOps();
    req_a[47:32] = 16'h3FC0;
    req_b[47:32] = 16'h4000;
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    idle(7);

    // Drain with operations in flight while requests stay pending.
    repeat (3) begin
      randOps();
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    end
    repeat (8) begin
      randOps();
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    end
    repeat (3) begin
      randOps();
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    end
    idle(7);

    // Spurious multiplier strobe with nothing in flight.
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Random traffic with occasional short drain requests.
    for (int n = 0; n < 400; n++) begin
      logic drn;
      randOps();
      if (drain_hold == 0 && $urandom_range(0, 24) == 0) drain_hold = $urandom_range(1, 8);
      drn = (drain_hold > 0);
      if (drain_hold > 0) drain_hold--;
      applyStimulus(4'($urandom), drn, 1'b0, 1'b0);
    end
    idle(7);

    // Reset in the middle of a burst; no stale responses may follow.
    repeat (3) begin
      randOps();
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1);
    idle(8);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
